// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: walks one full-adder cell over WIDTH-bit operands,
// LSB first, one bit per clock, behind a start/done handshake.
// Ports: clk, rst_n (sync, active-low), start, a, b, cin -> busy, done, sum, cout.
module serial_add_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             bit_s;
    logic             bit_c;
    logic             last;

    // The single shared full-adder cell.
    assign bit_s = a_sh[0] ^ b_sh[0] ^ carry;
    assign bit_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign last  = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode registered state only, so no input reaches an output
    // combinationally.
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sum_sh <= {bit_s, sum_sh[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= bit_c;
                    cnt    <= cnt + CW'(1);
                    // Result registers move only here, so the previous
                    // result stays visible for the whole run.
                    if (last) begin
                        sum  <= {bit_s, sum_sh[WIDTH-1:1]};
                        cout <= bit_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks for serial_add_ctrl at WIDTH=8 and WIDTH=16.
// Ports: none (top-level bench).
module tb_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        cin = 1'b0;
    logic        busy;
    logic        done;
    logic [7:0]  sum;
    logic        cout;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        cin16 = 1'b0;
    logic        busy16;
    logic        done16;
    logic [15:0] sum16;
    logic        cout16;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_add_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
        .cin(cin16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One full op on the 8-bit DUT; checks busy length, latency, pulse width,
    // and the result against the supplied expected {cout,sum}.
    task automatic op8(input logic [7:0] aa, input logic [7:0] bb,
                       input logic ci, input logic [8:0] exp,
                       input string tag);
        int lat;
        int bc;
        a = aa;
        b = bb;
        cin = ci;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        bc = busy ? 1 : 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
            if (busy) bc++;
        end
        check({tag, "_lat"}, lat, 8);
        check({tag, "_busy_cycles"}, bc, 8);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 0);
        check({tag, "_result"}, {23'd0, cout, sum}, {23'd0, exp});
        tick();
        check({tag, "_done_pulse"}, {31'd0, done}, 0);
    endtask

    initial begin
        int n;
        int dseen;
        int t_prev;
        int t_now;
        logic [8:0] exp3 [3];
        logic [7:0] opa [4];
        logic [7:0] opb [4];
        logic       opc [4];
        logic [8:0]  e8;
        logic [16:0] e16;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_sum", {23'd0, cout, sum}, 0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", {31'd0, busy}, 0);

        // Directed vectors
        op8(8'hFF, 8'h01, 1'b0, 9'h100, "t1");
        op8(8'h5A, 8'hA5, 1'b1, 9'h100, "t2a");
        op8(8'h3C, 8'h0F, 1'b0, 9'h04B, "t2b");

        // Mid-run start and operand changes are ignored
        a = 8'h77;
        b = 8'h11;
        cin = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 8'hFF;
        b = 8'hFF;
        cin = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t3_hold_prev", {23'd0, cout, sum}, 9'h04B);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check("t3_done_seen", {31'd0, done}, 1);
        check("t3_result", {23'd0, cout, sum}, 9'h089);
        tick();
        tick();
        check("t3_no_requeue", {31'd0, busy}, 0);

        // Reset during run at bit 4
        a = 8'hAA;
        b = 8'h55;
        cin = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t4_busy", {31'd0, busy}, 0);
        check("t4_done", {31'd0, done}, 0);
        check("t4_sum", {23'd0, cout, sum}, 0);
        dseen = 0;
        repeat (12) begin
            tick();
            if (done || busy) dseen++;
        end
        check("t4_quiet", dseen, 0);
        op8(8'h01, 8'h02, 1'b1, 9'h004, "t4_after");

        // Start held high: back-to-back ops
        opa[0] = 8'h12; opb[0] = 8'h34; opc[0] = 1'b0; exp3[0] = 9'h046;
        opa[1] = 8'hF0; opb[1] = 8'h10; opc[1] = 1'b1; exp3[1] = 9'h101;
        opa[2] = 8'h80; opb[2] = 8'h80; opc[2] = 1'b0; exp3[2] = 9'h100;
        opa[3] = 8'h00; opb[3] = 8'h00; opc[3] = 1'b0;
        a = opa[0];
        b = opb[0];
        cin = opc[0];
        start = 1'b1;
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!busy && n < 40) begin
                tick();
                n++;
            end
            check("t5_accept", {31'd0, busy}, 1);
            a = opa[k+1];
            b = opb[k+1];
            cin = opc[k+1];
            n = 0;
            while (!done && n < 40) begin
                tick();
                n++;
            end
            t_now = cyc;
            check("t5_result", {23'd0, cout, sum}, {23'd0, exp3[k]});
            if (k > 0) check("t5_spacing", t_now - t_prev, 10);
            t_prev = t_now;
        end
        start = 1'b0;
        tick();
        tick();
        tick();
        check("t5_stop", {31'd0, busy}, 0);

        // Random ops, WIDTH=8
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            cin = 1'($urandom);
            e8 = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            start = 1'b1;
            tick();
            start = 1'b0;
            n = 0;
            while (!done && n < 40) begin
                tick();
                n++;
            end
            check("rnd8", {23'd0, cout, sum}, {23'd0, e8});
            tick();
        end

        // Random ops, WIDTH=16
        for (int i = 0; i < 1000; i++) begin
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            cin16 = 1'($urandom);
            e16 = {1'b0, a16} + {1'b0, b16} + {16'd0, cin16};
            start16 = 1'b1;
            tick();
            start16 = 1'b0;
            n = 0;
            while (!done16 && n < 60) begin
                tick();
                n++;
            end
            check("rnd16_lat", n, 16);
            check("rnd16", {15'd0, cout16, sum16}, {15'd0, e16});
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
